// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for MULT, LSU, DIV and EXE with EXE anti-starvation boost.
// Define WB_PORT_ARBITER_PERF_EN to add conflict and boost-cycle performance counters.
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        EXE_reg_wr,
  input  logic [4:0]  EXE_reg_rd,
  input  logic [31:0] EXE_reg_data,
  input  logic        MULT_reg_wr,
  input  logic [4:0]  MULT_reg_rd,
  input  logic [31:0] MULT_reg_data,
  input  logic        DIV_reg_wr,
  input  logic [4:0]  DIV_reg_rd,
  input  logic [31:0] DIV_reg_data,
  output logic        DIV_reg_rdy,
  input  logic        LSU_reg_wr,
  input  logic [4:0]  LSU_reg_rd,
  input  logic [31:0] LSU_reg_data,
  output logic        LSU_reg_rdy,
  output logic        exe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
`ifdef WB_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_boost_cnt
`endif
);

  typedef enum logic [0:0] {StNormal, StBoost} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_mult, grant_lsu, grant_div, grant_exe, any_grant;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;

  // MULT cannot be stalled, so it always wins; BOOST lifts EXE above LSU/DIV.
  always_comb begin
    grant_mult = MULT_reg_wr;
    grant_exe  = 1'b0;
    grant_lsu  = 1'b0;
    grant_div  = 1'b0;
    if (!MULT_reg_wr) begin
      if (state_q == StBoost) begin
        if (EXE_reg_wr)      grant_exe = 1'b1;
        else if (LSU_reg_wr) grant_lsu = 1'b1;
        else if (DIV_reg_wr) grant_div = 1'b1;
      end else begin
        if (LSU_reg_wr)      grant_lsu = 1'b1;
        else if (DIV_reg_wr) grant_div = 1'b1;
        else if (EXE_reg_wr) grant_exe = 1'b1;
      end
    end
  end

  assign any_grant   = grant_mult | grant_lsu | grant_div | grant_exe;
  assign DIV_reg_rdy = rstn & DIV_reg_wr & grant_div;
  assign LSU_reg_rdy = rstn & LSU_reg_wr & grant_lsu;
  assign exe_stall   = rstn & EXE_reg_wr & ~grant_exe;

  always_comb begin
    sel_rd   = EXE_reg_rd;
    sel_data = EXE_reg_data;
    if (grant_mult) begin
      sel_rd   = MULT_reg_rd;
      sel_data = MULT_reg_data;
    end else if (grant_lsu) begin
      sel_rd   = LSU_reg_rd;
      sel_data = LSU_reg_data;
    end else if (grant_div) begin
      sel_rd   = DIV_reg_rd;
      sel_data = DIV_reg_data;
    end
  end

  // Boost is entered on the same edge the counter saturates.
  always_comb begin
    cnt_d = '0;
    if (exe_stall) begin
      cnt_d = (cnt_q == CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    state_d = state_q;
    unique case (state_q)
      StNormal: if (cnt_d == CNT_W'(STARVE_MAX)) state_d = StBoost;
      StBoost:  if (grant_exe || !EXE_reg_wr) state_d = StNormal;
      default:  state_d = StNormal;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StNormal;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // x0 writes are consumed but never reach the register file.
      rf_we_q <= any_grant && (sel_rd != 5'd0);
      if (any_grant) begin
        rf_waddr_q <= sel_rd;
        rf_wdata_q <= sel_data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0] perf_conflict_q, perf_boost_q;
  logic        conflict;

  assign conflict = exe_stall | (DIV_reg_wr & ~grant_div) | (LSU_reg_wr & ~grant_lsu);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_conflict_q <= '0;
      perf_boost_q    <= '0;
    end else begin
      if (conflict)              perf_conflict_q <= perf_conflict_q + 32'd1;
      if (state_q == StBoost)    perf_boost_q    <= perf_boost_q + 32'd1;
    end
  end

  assign perf_conflict_cnt = perf_conflict_q;
  assign perf_boost_cnt    = perf_boost_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// checked against a priority-list reference model.
module tb_wb_port_arbiter;
  localparam int unsigned StarveMax = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        EXE_reg_wr, MULT_reg_wr, DIV_reg_wr, LSU_reg_wr;
  logic [4:0]  EXE_reg_rd, MULT_reg_rd, DIV_reg_rd, LSU_reg_rd;
  logic [31:0] EXE_reg_data, MULT_reg_data, DIV_reg_data, LSU_reg_data;
  logic        DIV_reg_rdy, LSU_reg_rdy, exe_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_boost_cnt;
  logic [31:0] m_conf, m_bcnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state. Source index: 0 MULT, 1 EXE, 2 LSU, 3 DIV.
  bit          m_boost;
  int          m_cnt;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_win;
  bit          e_div_rdy, e_lsu_rdy, e_stall;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_MAX(StarveMax), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .EXE_reg_wr(EXE_reg_wr), .EXE_reg_rd(EXE_reg_rd), .EXE_reg_data(EXE_reg_data),
    .MULT_reg_wr(MULT_reg_wr), .MULT_reg_rd(MULT_reg_rd), .MULT_reg_data(MULT_reg_data),
    .DIV_reg_wr(DIV_reg_wr), .DIV_reg_rd(DIV_reg_rd), .DIV_reg_data(DIV_reg_data),
    .DIV_reg_rdy(DIV_reg_rdy),
    .LSU_reg_wr(LSU_reg_wr), .LSU_reg_rd(LSU_reg_rd), .LSU_reg_data(LSU_reg_data),
    .LSU_reg_rdy(LSU_reg_rdy),
    .exe_stall(exe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_PORT_ARBITER_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_boost_cnt(perf_boost_cnt)
`endif
  );

  task automatic model_reset();
    m_boost = 0;
    m_cnt   = 0;
    m_we    = 0;
    m_waddr = '0;
    m_wdata = '0;
`ifdef WB_PORT_ARBITER_PERF_EN
    m_conf  = '0;
    m_bcnt  = '0;
`endif
  endtask

  // Walk the current priority list and pick the first requester.
  task automatic model_eval();
    bit req[4];
    int order[4];
    req[0] = MULT_reg_wr;
    req[1] = EXE_reg_wr;
    req[2] = LSU_reg_wr;
    req[3] = DIV_reg_wr;
    if (m_boost) begin
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3;
    end else begin
      order[0] = 0; order[1] = 2; order[2] = 3; order[3] = 1;
    end
    m_win = -1;
    for (int i = 0; i < 4; i++) if (m_win < 0 && req[order[i]]) m_win = order[i];
    e_div_rdy = rstn && (m_win == 3);
    e_lsu_rdy = rstn && (m_win == 2);
    e_stall   = rstn && EXE_reg_wr && (m_win != 1);
  endtask

  task automatic model_commit();
    logic [4:0]  rds[4];
    logic [31:0] dat[4];
    model_eval();
    if (!rstn) return;
    rds[0] = MULT_reg_rd;   rds[1] = EXE_reg_rd;   rds[2] = LSU_reg_rd;   rds[3] = DIV_reg_rd;
    dat[0] = MULT_reg_data; dat[1] = EXE_reg_data; dat[2] = LSU_reg_data; dat[3] = DIV_reg_data;
    m_we = 0;
    if (m_win >= 0) begin
      m_we    = (rds[m_win] != 5'd0);
      m_waddr = rds[m_win];
      m_wdata = dat[m_win];
    end
`ifdef WB_PORT_ARBITER_PERF_EN
    if (e_stall || (DIV_reg_wr && m_win != 3) || (LSU_reg_wr && m_win != 2)) m_conf = m_conf + 1;
    if (m_boost) m_bcnt = m_bcnt + 1;
`endif
    if (e_stall) m_cnt = (m_cnt < int'(StarveMax)) ? m_cnt + 1 : m_cnt;
    else         m_cnt = 0;
    if (m_boost) m_boost = e_stall;
    else         m_boost = (m_cnt == int'(StarveMax));
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    EXE_reg_wr = 0; MULT_reg_wr = 0; DIV_reg_wr = 0; LSU_reg_wr = 0;
  endtask

  task automatic test_reset();
    idle();
    EXE_reg_rd = 0; MULT_reg_rd = 0; DIV_reg_rd = 0; LSU_reg_rd = 0;
    EXE_reg_data = 0; MULT_reg_data = 0; DIV_reg_data = 0; LSU_reg_data = 0;
    model_reset();
    EXE_reg_wr = 1; DIV_reg_wr = 1; LSU_reg_wr = 1;
    #2;
    checks++; if (DIV_reg_rdy !== 1'b0) begin errors++; $display("FAIL reset_div_rdy got %b want 0", DIV_reg_rdy); end
    checks++; if (LSU_reg_rdy !== 1'b0) begin errors++; $display("FAIL reset_lsu_rdy got %b want 0", LSU_reg_rdy); end
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", exe_stall); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    idle();
    rstn = 1;
    tick();
  endtask

  task automatic test_single();
    idle();
    EXE_reg_wr = 1; EXE_reg_rd = 5; EXE_reg_data = 32'h1234_5678;
    #1;
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL single_stall got %b want 0", exe_stall); end
    tick();
    EXE_reg_wr = 0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL single_wdata got %h want 12345678", rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL idle_hold_waddr got %0d want 5", rf_waddr); end
  endtask

  task automatic test_collision();
    idle();
    MULT_reg_wr = 1; MULT_reg_rd = 3; MULT_reg_data = 32'hAAAA_0000;
    EXE_reg_wr = 1; EXE_reg_rd = 4; EXE_reg_data = 32'h0000_4444;
    #1;
    checks++; if (exe_stall !== 1'b1) begin errors++; $display("FAIL coll_stall got %b want 1", exe_stall); end
    tick();
    MULT_reg_wr = 0;
    #1;
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL coll_stall2 got %b want 0", exe_stall); end
    checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL coll_mult_waddr got %0d want 3", rf_waddr); end
    checks++; if (rf_wdata !== 32'hAAAA_0000) begin errors++; $display("FAIL coll_mult_wdata got %h want aaaa0000", rf_wdata); end
    tick();
    EXE_reg_wr = 0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL coll_exe_we got %b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd4) begin errors++; $display("FAIL coll_exe_waddr got %0d want 4", rf_waddr); end
    tick();
  endtask

  task automatic test_handshake();
    idle();
    LSU_reg_wr = 1; LSU_reg_rd = 7; LSU_reg_data = 32'h77;
    DIV_reg_wr = 1; DIV_reg_rd = 9; DIV_reg_data = 32'h99;
    #1;
    checks++; if (LSU_reg_rdy !== 1'b1) begin errors++; $display("FAIL hs_lsu_rdy got %b want 1", LSU_reg_rdy); end
    checks++; if (DIV_reg_rdy !== 1'b0) begin errors++; $display("FAIL hs_div_rdy got %b want 0", DIV_reg_rdy); end
    tick();
    LSU_reg_wr = 0;
    #1;
    checks++; if (DIV_reg_rdy !== 1'b1) begin errors++; $display("FAIL hs_div_rdy2 got %b want 1", DIV_reg_rdy); end
    checks++; if (rf_wdata !== 32'h77) begin errors++; $display("FAIL hs_lsu_wdata got %h want 77", rf_wdata); end
    tick();
    DIV_reg_wr = 0;
    checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL hs_div_waddr got %0d want 9", rf_waddr); end
    checks++; if (rf_wdata !== 32'h99) begin errors++; $display("FAIL hs_div_wdata got %h want 99", rf_wdata); end
    tick();
  endtask

  task automatic test_starvation();
    idle();
    EXE_reg_wr = 1; EXE_reg_rd = 10; EXE_reg_data = 32'hE0;
    LSU_reg_wr = 1;
    for (int c = 0; c < 5; c++) begin
      LSU_reg_rd = 5'(c + 1); LSU_reg_data = 32'h1000 + 32'(c);
      #1;
      checks++; if (exe_stall !== (c < 4)) begin errors++; $display("FAIL starve_stall c=%0d got %b want %b", c, exe_stall, (c < 4)); end
      checks++; if (LSU_reg_rdy !== (c < 4)) begin errors++; $display("FAIL starve_lsu_rdy c=%0d got %b want %b", c, LSU_reg_rdy, (c < 4)); end
      tick();
    end
    EXE_reg_rd = 11; EXE_reg_data = 32'hE1;
    #1;
    checks++; if (rf_waddr !== 5'd10) begin errors++; $display("FAIL starve_exe_waddr got %0d want 10", rf_waddr); end
    checks++; if (exe_stall !== 1'b1) begin errors++; $display("FAIL starve_back_normal got %b want 1", exe_stall); end
    idle();
    tick();
    tick();
  endtask

  task automatic test_x0();
    idle();
    EXE_reg_wr = 1; EXE_reg_rd = 0; EXE_reg_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", exe_stall); end
    tick();
    EXE_reg_wr = 0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL x0_waddr got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL x0_wdata got %h want ffffffff", rf_wdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    MULT_reg_wr = 1; MULT_reg_rd = 2; MULT_reg_data = 32'h22;
    DIV_reg_wr = 1; DIV_reg_rd = 6; DIV_reg_data = 32'h66;
    EXE_reg_wr = 1; EXE_reg_rd = 8; EXE_reg_data = 32'h88;
    tick();
    MULT_reg_rd = 3; MULT_reg_data = 32'h33;
    #1;
    checks++; if (exe_stall !== 1'b1) begin errors++; $display("FAIL rmid_stall_pre got %b want 1", exe_stall); end
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rmid_we_pre got %b want 1", rf_we); end
    #2;
    rstn = 0;
    model_reset();
    #1;
    checks++; if (DIV_reg_rdy !== 1'b0) begin errors++; $display("FAIL rmid_div_rdy got %b want 0", DIV_reg_rdy); end
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", exe_stall); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_we got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL rmid_waddr got %0d want 0", rf_waddr); end
    #1;
    rstn = 1;
    MULT_reg_wr = 0; EXE_reg_wr = 0;
    #1;
    checks++; if (DIV_reg_rdy !== 1'b1) begin errors++; $display("FAIL rmid_div_rdy_post got %b want 1", DIV_reg_rdy); end
    tick();
    DIV_reg_wr = 0;
    checks++; if (rf_waddr !== 5'd6) begin errors++; $display("FAIL rmid_div_waddr got %0d want 6", rf_waddr); end
    checks++; if (rf_wdata !== 32'h66) begin errors++; $display("FAIL rmid_div_wdata got %h want 66", rf_wdata); end
    tick();
  endtask

  task automatic test_random();
    bit div_acc = 1, lsu_acc = 1, exe_held = 0, mult_prev = 0;
    idle();
    for (int n = 0; n < 600; n++) begin
      if (!DIV_reg_wr || div_acc) begin
        DIV_reg_wr = ($urandom_range(0, 2) != 0);
        DIV_reg_rd = 5'($urandom); DIV_reg_data = $urandom;
      end
      if (!LSU_reg_wr || lsu_acc) begin
        LSU_reg_wr = ($urandom_range(0, 2) != 0);
        LSU_reg_rd = 5'($urandom); LSU_reg_data = $urandom;
      end
      if (!exe_held) begin
        EXE_reg_wr = ($urandom_range(0, 3) != 0);
        EXE_reg_rd = 5'($urandom); EXE_reg_data = $urandom;
      end
      // MULT never repeats its rd on consecutive cycles.
      if (mult_prev) MULT_reg_rd = MULT_reg_rd + 5'($urandom_range(1, 31));
      else           MULT_reg_rd = 5'($urandom);
      MULT_reg_wr = ($urandom_range(0, 3) == 0);
      MULT_reg_data = $urandom;
      mult_prev = MULT_reg_wr;
      #1;
      model_eval();
      checks++; if (DIV_reg_rdy !== e_div_rdy) begin errors++; $display("FAIL rnd_div_rdy n=%0d got %b want %b", n, DIV_reg_rdy, e_div_rdy); end
      checks++; if (LSU_reg_rdy !== e_lsu_rdy) begin errors++; $display("FAIL rnd_lsu_rdy n=%0d got %b want %b", n, LSU_reg_rdy, e_lsu_rdy); end
      checks++; if (exe_stall !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %b want %b", n, exe_stall, e_stall); end
      div_acc = e_div_rdy; lsu_acc = e_lsu_rdy; exe_held = e_stall;
      tick();
      checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_we n=%0d got %b want %b", n, rf_we, m_we); end
      checks++; if (rf_waddr !== m_waddr) begin errors++; $display("FAIL rnd_waddr n=%0d got %0d want %0d", n, rf_waddr, m_waddr); end
      checks++; if (rf_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata n=%0d got %h want %h", n, rf_wdata, m_wdata); end
`ifdef WB_PORT_ARBITER_PERF_EN
      checks++; if (perf_conflict_cnt !== m_conf) begin errors++; $display("FAIL rnd_perf_conf n=%0d got %0d want %0d", n, perf_conflict_cnt, m_conf); end
      checks++; if (perf_boost_cnt !== m_bcnt) begin errors++; $display("FAIL rnd_perf_boost n=%0d got %0d want %0d", n, perf_boost_cnt, m_bcnt); end
`endif
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_handshake();
    test_starvation();
    test_x0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
